fetch_sequencer: RTL

Instruction fetch and sequencing block for the accumulator CPU: owns the program counter, instruction memory and Z/N/C/V status register, and presents `opcode`, `literal` and `status` to the control decoder. It consumes the decoder's `LP` (jump) result to choose the next PC. It also provides a load port for writing the program into instruction memory before execution starts.

---
 rtl/fetch_sequencer_pkg.sv | 33 +++
 rtl/fetch_sequencer_instr_mem.sv | 31 +++
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the accumulator CPU fetch/sequencing path.
// Optional feature macro: FETCH_SINGLE_STEP_EN (adds the PAUSE state).
package cpu_pkg;

    localparam int unsigned OP_W = 7;
    localparam logic [OP_W-1:0] OP_HALT = 7'h7F;

    // Bit positions inside the {Z,N,C,V} status nibble
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Instruction word is {opcode, literal}; default literal width is 8
    localparam int unsigned INSTR_W = OP_W + 8;

    function automatic int unsigned instr_width(input int unsigned k_w);
        return OP_W + k_w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
`ifdef FETCH_SINGLE_STEP_EN
        ST_HALT,
        ST_PAUSE
`else
        ST_HALT
`endif
    } state_e;

endpackage

// File: rtl/fetch_sequencer_instr_mem.sv
// Instruction memory: simple dual-port RAM, synchronous write (load side)
// and synchronous registered read (fetch side). Contents are not reset.
module instr_mem #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 15
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // Write on load request; read register only updates when a fetch is issued
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and sequencing: PC, instruction memory, status register
// and the IDLE/FETCH/EXEC/HALT control FSM.
// Optional feature macro: FETCH_SINGLE_STEP_EN (step input + PAUSE state).
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 8,
    parameter int unsigned K_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [PC_W-1:0]   ld_addr,
    input  logic [OP_W+K_W-1:0] ld_data,
    input  logic              LP,
    input  logic [3:0]        flags_in,
    input  logic              flags_we,
    output logic [OP_W-1:0]   opcode,
    output logic [K_W-1:0]    literal,
    output logic [3:0]        status,
    output logic [PC_W-1:0]   pc,
    output logic              instr_valid,
    output logic              halted
);

    localparam int unsigned IW = OP_W + K_W;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [3:0]        status_q, status_d;
    logic [IW-1:0]     ir_q;
    logic              mem_we;
    logic              mem_re;
    logic [OP_W-1:0]   ir_op;
    logic [K_W-1:0]    ir_lit;

    // The RAM's registered read data is the instruction register: it only
    // reloads during FETCH, so it holds the word throughout EXEC.
    instr_mem #(
        .AW (PC_W),
        .DW (IW)
    ) u_imem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .re_i    (mem_re),
        .raddr_i (pc_q),
        .rdata_o (ir_q)
    );

    assign ir_op  = ir_q[IW-1:K_W];
    assign ir_lit = ir_q[K_W-1:0];

    // Next-state, PC, status and memory-strobe logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        status_d = status_q;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                mem_we = ld_valid & ~rst;
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_re  = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (ir_op == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = LP ? PC_W'(ir_lit) : pc_q + 1'b1;
                    if (flags_we) begin
                        status_d = flags_in;
                    end
`ifdef FETCH_SINGLE_STEP_EN
                    state_d = ST_PAUSE;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef FETCH_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (step) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State, PC and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            status_q <= status_d;
        end
    end

    assign instr_valid = (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALT);
    assign ld_ready    = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign opcode      = instr_valid ? ir_op  : OP_HALT;
    assign literal     = instr_valid ? ir_lit : '0;
    assign status      = status_q;
    assign pc          = pc_q;

endmodule
